// File: rtl/shift_chain_pkg.sv
// shift_chain_pkg: shared types and helpers for the
// parametrised multi-word shift chain.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    FWD  = 2'b00,
    REV  = 2'b01,
    ROTF = 2'b10,
    ROTR = 2'b11
  } shift_mode_e;

  function automatic int fill_width(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one WIDTH-bit word of the chain.
// Priority clr > ld > en > hold.
module shift_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] pin_k,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic             sel_left,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;

  // next word: clear, load, take a neighbour, or hold
  always_comb begin
    word_d = word_q;
    if (clr)     word_d = '0;
    else if (ld) word_d = pin_k;
    else if (en) word_d = sel_left ? left_i : right_i;
  end

  // word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/shift_chain_p.sv
// shift_chain_p: parametrised shift/rotate delay line
// with parallel load, clear and fill tracking.
module shift_chain_p
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 9,
  parameter int CW    = fill_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] pin [0:DEPTH-1],
  input  logic [WIDTH-1:0] si,
  output logic [WIDTH-1:0] so,
  output logic [WIDTH-1:0] out [0:DEPTH-1],
  output logic [CW-1:0]    fill,
  output logic             full,
  output logic             so_vld
);

  shift_mode_e      mode_e;
  logic             sel_left;
  logic             is_shift;
  logic [WIDTH-1:0] left_end;
  logic [WIDTH-1:0] right_end;
  logic [WIDTH-1:0] left_w  [0:DEPTH-1];
  logic [WIDTH-1:0] right_w [0:DEPTH-1];
  logic [CW-1:0]    fill_d;
  logic [CW-1:0]    fill_q;

  assign mode_e    = shift_mode_e'(mode);
  assign sel_left  = (mode_e == FWD) || (mode_e == ROTF);
  assign is_shift  = (mode_e == FWD) || (mode_e == REV);
  assign left_end  = (mode_e == ROTF) ? out[DEPTH-1] : si;
  assign right_end = (mode_e == ROTR) ? out[0] : si;

  // neighbour words; end stages see si or the wrap word
  always_comb begin
    left_w[0]        = left_end;
    right_w[DEPTH-1] = right_end;
    for (int k = 1; k < DEPTH; k++) begin
      left_w[k]    = out[k-1];
      right_w[k-1] = out[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .ld       (ld),
      .en       (en),
      .pin_k    (pin[k]),
      .left_i   (left_w[k]),
      .right_i  (right_w[k]),
      .sel_left (sel_left),
      .q        (out[k])
    );
  end

  // fill count: saturating, only shifts bring words in
  always_comb begin
    fill_d = fill_q;
    if (clr)
      fill_d = '0;
    else if (ld)
      fill_d = CW'(DEPTH);
    else if (en && is_shift && !full)
      fill_d = fill_q + CW'(1);
  end

  // fill register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  assign fill   = fill_q;
  assign full   = (fill_q == CW'(DEPTH));
  assign so     = sel_left ? out[DEPTH-1] : out[0];
  assign so_vld = en & ~clr & ~ld & full & is_shift;

endmodule

// File: tb/tb_shift_chain_p.sv
// tb_shift_chain_p: table vectors plus a reference
// model feeding a scoreboard queue.
module tb_shift_chain_p;

  localparam int W  = 4;
  localparam int D  = 9;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         clr;
  logic         ld;
  logic [W-1:0] pin [0:D-1];
  logic [W-1:0] si;
  logic [W-1:0] so;
  logic [W-1:0] out [0:D-1];
  logic [CW-1:0] fill;
  logic         full;
  logic         so_vld;

  shift_chain_p #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .clr    (clr),
    .ld     (ld),
    .pin    (pin),
    .si     (si),
    .so     (so),
    .out    (out),
    .fill   (fill),
    .full   (full),
    .so_vld (so_vld)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W*D-1:0] o;
    int             f;
  } exp_t;

  typedef struct {
    logic [W-1:0] si;
    int           fill;
    logic [W-1:0] o0;
    logic [W-1:0] o8;
    logic         vld;
    logic [W-1:0] so;
  } vec_t;

  exp_t         sbq [$];
  logic [W-1:0] m [0:D-1];
  int           mf;
  logic         pre_vld;
  logic [W-1:0] pre_so;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W*D-1:0] pack_dut();
    logic [W*D-1:0] r;
    for (int k = 0; k < D; k++) r[k*W +: W] = out[k];
    return r;
  endfunction

  function automatic logic [W*D-1:0] pack_m();
    logic [W*D-1:0] r;
    for (int k = 0; k < D; k++) r[k*W +: W] = m[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) m[k] = '0;
    mf = 0;
  endtask

  // one clock: drive, check pre-edge outputs, predict, edge, compare
  task automatic step(bit c, bit l, bit e, logic [1:0] md,
                      logic [W-1:0] s);
    logic [W-1:0] n [0:D-1];
    exp_t x;
    clr = c; ld = l; en = e; mode = md; si = s;
    #1;
    pre_so  = md[0] ? m[0] : m[D-1];
    pre_vld = e && !c && !l && (mf == D) && !md[1];
    chk("so_pre", so, pre_so);
    chk("so_vld_pre", so_vld, pre_vld);
    n = m;
    if (c) begin
      for (int k = 0; k < D; k++) n[k] = '0;
      mf = 0;
    end else if (l) begin
      n = pin;
      mf = D;
    end else if (e) begin
      case (md)
        2'b00: begin
          n[0] = s;
          for (int k = 1; k < D; k++) n[k] = m[k-1];
          if (mf < D) mf++;
        end
        2'b01: begin
          n[D-1] = s;
          for (int k = 0; k < D-1; k++) n[k] = m[k+1];
          if (mf < D) mf++;
        end
        2'b10: begin
          n[0] = m[D-1];
          for (int k = 1; k < D; k++) n[k] = m[k-1];
        end
        default: begin
          n[D-1] = m[0];
          for (int k = 0; k < D-1; k++) n[k] = m[k+1];
        end
      endcase
    end
    m = n;
    x.o = pack_m();
    x.f = mf;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk("out", pack_dut(), x.o);
    chk("fill", fill, x.f);
    chk("full", full, x.f == D);
  endtask

  vec_t vt [0:9];

  initial begin
    for (int i = 0; i < 9; i++) begin
      vt[i].si   = 4'h6;
      vt[i].fill = i + 1;
      vt[i].o0   = 4'h6;
      vt[i].o8   = (i == 8) ? 4'h6 : 4'h0;
      vt[i].vld  = 1'b0;
      vt[i].so   = 4'h0;
    end
    vt[9] = '{si: 4'hB, fill: 9, o0: 4'hB, o8: 4'h6,
              vld: 1'b1, so: 4'h6};

    // 1. reset with random inputs
    rst_n = 1'b0;
    en = 1'b1; clr = 1'b0; ld = 1'b1; mode = 2'b00;
    si = 4'($urandom);
    for (int k = 0; k < D; k++) pin[k] = 4'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", pack_dut(), '0);
    chk("rst_fill", fill, 0);
    chk("rst_full", full, 0);
    chk("rst_so", so, 0);
    chk("rst_vld", so_vld, 0);
    en = 1'b0; ld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00, 4'($urandom));

    // 2. forward fill, table driven
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 2'b00, vt[i].si);
      chk($sformatf("tv%0d_vld", i), pre_vld, vt[i].vld);
      if (vt[i].vld) chk($sformatf("tv%0d_so", i), so === 4'hx ? 4'h0 : pre_so, vt[i].so);
      chk($sformatf("tv%0d_fill", i), fill, vt[i].fill);
      chk($sformatf("tv%0d_o0", i), out[0], vt[i].o0);
      chk($sformatf("tv%0d_o8", i), out[8], vt[i].o8);
    end

    // 3. load then rotate / reverse
    for (int k = 0; k < D; k++) pin[k] = 4'(k);
    step(0, 1, 0, 2'b00, 4'h0);
    step(0, 0, 1, 2'b10, 4'hE);
    chk("rotf_o0", out[0], 4'h8);
    chk("rotf_o1", out[1], 4'h0);
    chk("rotf_o8", out[8], 4'h7);
    step(0, 0, 1, 2'b11, 4'hE);
    step(0, 0, 1, 2'b11, 4'hE);
    chk("rotr_o0", out[0], 4'h1);
    chk("rotr_o8", out[8], 4'h0);
    step(0, 0, 1, 2'b01, 4'hF);
    chk("rev_so_pre", pre_so, 4'h1);
    chk("rev_o8", out[8], 4'hF);
    chk("rev_o0", out[0], 4'h2);

    // 4. priority
    step(1, 1, 1, 2'b00, 4'h3);
    chk("pri_clr_fill", fill, 0);
    chk("pri_clr_out", pack_dut(), '0);
    step(0, 1, 1, 2'b00, 4'h3);
    chk("pri_ld_fill", fill, 9);
    chk("pri_ld_o5", out[5], 4'h5);

    // 5. hold with en toggling, then saturation
    step(1, 0, 0, 2'b00, 4'h0);
    step(0, 0, 1, 2'b00, 4'h1);
    step(0, 0, 0, 2'b00, 4'h9);
    step(0, 0, 1, 2'b00, 4'h2);
    step(0, 0, 0, 2'b00, 4'h9);
    step(0, 0, 1, 2'b00, 4'h3);
    chk("hold_o0", out[0], 4'h3);
    chk("hold_o1", out[1], 4'h2);
    chk("hold_o2", out[2], 4'h1);
    chk("hold_fill", fill, 3);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 2'b00, 4'($urandom));
    chk("sat_fill", fill, 9);

    // 6. async reset mid-shift
    step(1, 0, 0, 2'b00, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'b00, 4'hA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out", pack_dut(), '0);
    chk("arst_fill", fill, 0);
    chk("arst_so", so, 0);
    @(posedge clk); #1;
    chk("arst_hold", fill, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 2'b00, 4'h5);
    chk("arst_first_fill", fill, 1);
    chk("arst_first_o0", out[0], 4'h5);

    chk("sbq_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_chain_p.md
Name: shift_chain_p

Overview:
Parametrised multi-word shift register / delay line, the successor to the fixed 4-bit x 9-stage shifter. It adds configurable word width and depth, and four shift modes: forward shift, reverse shift, forward rotate and reverse rotate. It also adds synchronous clear, parallel load, and fill tracking with a full flag. It is used as a tapped delay line and as a word FIFO-like buffer in the lab datapaths.

Parameters:
WIDTH, 4, bits per word.
DEPTH, 9, number of stages (legal range 2..64).
CW, $clog2(DEPTH+1), width of the fill counter (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  shift/rotate enable; when 0 the register holds.
mode  input  2  shift mode, decoded per shift_mode_e.
clr  input  1  synchronous clear.
ld  input  1  synchronous parallel load.
pin  input  WIDTH x DEPTH (unpacked [0:DEPTH-1])  parallel load data.
si  input  WIDTH  serial word in.
so  output  WIDTH  serial word out (the word that would be ejected).
out  output  WIDTH x DEPTH (unpacked [0:DEPTH-1])  stage taps.
fill  output  CW  count of valid words held, 0..DEPTH.
full  output  1  high when fill == DEPTH.
so_vld  output  1  the ejected word this cycle is valid.

Behaviour:
- Reset: rst_n low asynchronously forces every out[k] = 0 and fill = 0; full = 0, so = 0, so_vld = 0.
- Reset may assert mid-operation; the state clears immediately and no partial shift completes.
- Priority on each rising edge: clr > ld > en > hold.
- clr = 1: all stages become 0, fill becomes 0; mode and en are ignored.
- ld = 1 (clr = 0): out[k] <= pin[k] for all k; fill <= DEPTH.
- en = 1 (clr = 0, ld = 0), by mode:
  - FWD (00): out[0] <= si; out[k] <= out[k-1] for k = 1..DEPTH-1; fill increments, saturating at DEPTH.
  - REV (01): out[DEPTH-1] <= si; out[k] <= out[k+1]; fill increments, saturating at DEPTH.
  - ROTF (10): out[0] <= out[DEPTH-1]; other stages as in FWD; si is ignored; fill unchanged.
  - ROTR (11): out[DEPTH-1] <= out[0]; other stages as in REV; si is ignored; fill unchanged.
- en = 0 with no clr/ld: all state holds.
- so is combinational from registers only (no dependency on si): out[DEPTH-1] for FWD/ROTF, out[0] for REV/ROTR.
- so_vld = en & ~clr & ~ld & full & (mode is FWD or REV), i.e. a valid word leaves the chain this edge.
- Latency: si presented in FWD with en is visible at out[0] one cycle later, and at so after DEPTH enabled cycles.
- full = (fill == DEPTH), combinational from fill.
- The fill counter never wraps; it stays at DEPTH under continued shifting.
- Changing mode between cycles is legal and takes effect on the next edge.
- Fill counts words shifted in, independent of direction.

Decomposition:
- Package shift_chain_pkg holds:
  - typedef enum logic [1:0] shift_mode_e {FWD, REV, ROTF, ROTR};
  - function fill_width(depth) returning $clog2(depth+1).
- Sub-module shift_stage is a single WIDTH-bit register with async active-low reset.
  - Inputs: clr, ld, en, pin_k, left-neighbour word, right-neighbour word, sel_left.
  - The top level generates DEPTH instances; end stages get si or the wrap word as the neighbour input.
- The fill counter and so/so_vld logic live in the top level.

Test Plan:
1. Reset: rst_n = 0 with random pin/si -> all out = 0, fill = 0, full = 0, so = 0; release, hold en = 0 for 5 cycles -> still all 0.
2. Forward fill (WIDTH = 4, DEPTH = 9):
   - FWD, en = 1, si = 4'h6 for 9 cycles -> out[0..8] = 6, fill increments 1..9, full rises on edge 9.
   - Then si = 4'hB for 1 cycle -> so_vld = 1 with so = 6 during that cycle, out[0] = B, fill stays 9.
3. Reverse and rotate:
   - Load pin = {0,1,..,8}; ROTF one edge -> out = {8,0,1,..,7}, fill = 9.
   - ROTR twice -> out = {1,2,..,8,0}.
   - REV with si = F -> out[8] = F, so before the edge = 1.
4. Priority: clr = 1, ld = 1, en = 1 together -> all 0, fill = 0. Next edge with ld = 1, en = 1 -> out = pin, fill = 9.
5. Hold/saturation:
   - en toggling 1/0 with FWD si = 1,2,3 -> stages advance only on en = 1 edges.
   - 20 FWD shifts -> fill stays at 9 and never wraps to 0.
6. Async reset mid-shift: assert rst_n low between edges after 4 shifts -> outputs clear before the next edge; the first shift after release produces fill = 1.
